// File: rtl/reloj_hora_ajustable_pkg.sv
// Shared constants for the adjustable time-of-day keeper: button bit positions,
// edit-field codes, FSM encoding and the 24 h -> 12 h hour mapping.
package reloj_hora_ajustable_pkg;

    localparam int BTN_UP  = 3;
    localparam int BTN_DN  = 2;
    localparam int BTN_IZQ = 1;
    localparam int BTN_DER = 0;

    localparam logic [1:0] CAMPO_SEG  = 2'd0;
    localparam logic [1:0] CAMPO_MIN  = 2'd1;
    localparam logic [1:0] CAMPO_HORA = 2'd2;

    localparam logic [1:0] EDIT_CODE_DEF = 2'b01;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_EDIT = 1'b1;

    // 00 -> 12, 01..12 unchanged, 13..23 -> 01..11; input and output are BCD.
    function automatic logic [7:0] hora_a_12h(input logic [7:0] hora);
        logic [4:0] bin;
        logic [4:0] r;
        bin = 5'(hora[7:4]) * 5'd10 + 5'(hora[3:0]);
        if (bin == 5'd0)
            r = 5'd12;
        else if (bin > 5'd12)
            r = bin - 5'd12;
        else
            r = bin;
        if (r >= 5'd10)
            return {4'd1, 4'(r - 5'd10)};
        else
            return {4'd0, r[3:0]};
    endfunction

endpackage

// File: rtl/reloj_hora_ajustable_contador.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX; carry flags an
// incrementing wrap so counters can be chained.
module contador_bcd_mod
    import reloj_hora_ajustable_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] valor,
    output logic       carry
);

    localparam logic [3:0] MAX_DEC = 4'(MAX / 10);
    localparam logic [3:0] MAX_UNI = 4'(MAX % 10);

    logic [3:0] decenas_reg, decenas_next;
    logic [3:0] unidades_reg, unidades_next;
    logic       en_max, en_cero;

    assign en_max  = (decenas_reg == MAX_DEC) && (unidades_reg == MAX_UNI);
    assign en_cero = (decenas_reg == 4'd0) && (unidades_reg == 4'd0);

    // inc wins if both are requested; the top never asserts both anyway.
    always_comb begin
        decenas_next  = decenas_reg;
        unidades_next = unidades_reg;
        if (inc) begin
            if (en_max) begin
                decenas_next  = 4'd0;
                unidades_next = 4'd0;
            end else if (unidades_reg == 4'd9) begin
                decenas_next  = decenas_reg + 4'd1;
                unidades_next = 4'd0;
            end else begin
                unidades_next = unidades_reg + 4'd1;
            end
        end else if (dec) begin
            if (en_cero) begin
                decenas_next  = MAX_DEC;
                unidades_next = MAX_UNI;
            end else if (unidades_reg == 4'd0) begin
                decenas_next  = decenas_reg - 4'd1;
                unidades_next = 4'd9;
            end else begin
                unidades_next = unidades_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decenas_reg  <= 4'd0;
            unidades_reg <= 4'd0;
        end else begin
            decenas_reg  <= decenas_next;
            unidades_reg <= unidades_next;
        end
    end

    assign valor = {decenas_reg, unidades_reg};
    assign carry = inc && en_max;

endmodule

// File: rtl/reloj_hora_ajustable.sv
// Time-of-day keeper: counts h:m:s from a 1 Hz enable in RUN and lets the user
// edit one field at a time with edge-detected buttons in EDIT.
module reloj_hora_ajustable
    import reloj_hora_ajustable_pkg::*;
#(
    parameter logic [1:0] EDIT_CODE = EDIT_CODE_DEF,
    parameter int         TICK_DIV  = 1
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       tick_1hz,
    input  logic [1:0] Control,
    input  logic       F_H,
    input  logic [3:0] IN_bot_hora,
    output logic [7:0] seg_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hora_bcd,
    output logic       pm,
    output logic [1:0] campo,
    output logic       editando,
    output logic       fin_dia
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [0:0]       estado_reg;
    logic [1:0]       campo_reg;
    logic [3:0]       btn_prev_reg;
    logic [DIV_W-1:0] div_reg;
    logic             fin_dia_reg;

    logic       en_edicion;
    logic [3:0] pulsos;
    logic       act_up, act_dn, act_izq, act_der;
    logic       tick_valido;

    logic [2:0] inc_campo;
    logic [2:0] dec_campo;
    logic [2:0] carry_campo;
    logic [7:0] valor_campo [3];

    assign en_edicion = (estado_reg == ST_EDIT);
    assign pulsos     = IN_bot_hora & ~btn_prev_reg;

    // One action per cycle, up > down > left > right.
    assign act_up  = en_edicion && pulsos[BTN_UP];
    assign act_dn  = en_edicion && pulsos[BTN_DN] && !pulsos[BTN_UP];
    assign act_izq = en_edicion && pulsos[BTN_IZQ] && !pulsos[BTN_UP] && !pulsos[BTN_DN];
    assign act_der = en_edicion && pulsos[BTN_DER] && !pulsos[BTN_UP] && !pulsos[BTN_DN]
                     && !pulsos[BTN_IZQ];

    assign tick_valido = !en_edicion && tick_1hz && (div_reg == DIV_W'(TICK_DIV - 1));

    // Field 0 = seg, 1 = min, 2 = hora; carries only ripple while running.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_campo
            if (gi == 0) begin : g_base
                assign inc_campo[gi] = tick_valido || (act_up && campo_reg == 2'(gi));
            end else begin : g_cadena
                assign inc_campo[gi] = (!en_edicion && carry_campo[gi-1])
                                       || (act_up && campo_reg == 2'(gi));
            end
            assign dec_campo[gi] = act_dn && (campo_reg == 2'(gi));

            contador_bcd_mod #(
                .MAX((gi == 2) ? 23 : 59)
            ) u_contador (
                .clk  (reloj),
                .rst_n(resetM),
                .inc  (inc_campo[gi]),
                .dec  (dec_campo[gi]),
                .valor(valor_campo[gi]),
                .carry(carry_campo[gi])
            );
        end
    endgenerate

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            estado_reg   <= ST_RUN;
            campo_reg    <= CAMPO_HORA;
            btn_prev_reg <= 4'b0000;
            div_reg      <= '0;
            fin_dia_reg  <= 1'b0;
        end else begin
            btn_prev_reg <= IN_bot_hora;
            fin_dia_reg  <= !en_edicion && carry_campo[2];

            if (!en_edicion && tick_1hz)
                div_reg <= tick_valido ? '0 : DIV_W'(div_reg + 1'b1);

            case (estado_reg)
                ST_RUN: begin
                    if (Control == EDIT_CODE) begin
                        estado_reg <= ST_EDIT;
                        campo_reg  <= CAMPO_HORA;
                    end
                end
                default: begin
                    if (Control != EDIT_CODE)
                        estado_reg <= ST_RUN;
                    if (act_izq && campo_reg != CAMPO_HORA)
                        campo_reg <= campo_reg + 2'd1;
                    else if (act_der && campo_reg != CAMPO_SEG)
                        campo_reg <= campo_reg - 2'd1;
                end
            endcase
        end
    end

    assign seg_bcd  = valor_campo[0];
    assign min_bcd  = valor_campo[1];
    assign hora_bcd = F_H ? hora_a_12h(valor_campo[2]) : valor_campo[2];
    assign pm       = (valor_campo[2] >= 8'h12);
    assign campo    = campo_reg;
    assign editando = en_edicion;
    assign fin_dia  = fin_dia_reg;

endmodule

// File: tb/tb_reloj_hora_ajustable.sv
// Directed bench for reloj_hora_ajustable: expected output snapshots are queued
// as stimulus is applied and compared when the DUT has produced them.
module tb_reloj_hora_ajustable;

    logic       reloj = 1'b0;
    logic       resetM = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [1:0] Control = 2'b00;
    logic       F_H = 1'b0;
    logic [3:0] IN_bot_hora = 4'b0000;
    logic [7:0] seg_bcd, min_bcd, hora_bcd;
    logic       pm, editando, fin_dia;
    logic [1:0] campo;

    reloj_hora_ajustable #(
        .EDIT_CODE(2'b01),
        .TICK_DIV (1)
    ) dut (
        .reloj      (reloj),
        .resetM     (resetM),
        .tick_1hz   (tick_1hz),
        .Control    (Control),
        .F_H        (F_H),
        .IN_bot_hora(IN_bot_hora),
        .seg_bcd    (seg_bcd),
        .min_bcd    (min_bcd),
        .hora_bcd   (hora_bcd),
        .pm         (pm),
        .campo      (campo),
        .editando   (editando),
        .fin_dia    (fin_dia)
    );

    always #5 reloj = ~reloj;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] min;
        logic [7:0] hora;
        logic       pm;
        logic [1:0] campo;
        logic       ed;
        logic       fd;
    } snap_t;

    typedef struct {
        string tag;
        snap_t exp;
    } entry_t;

    entry_t sb[$];
    int total = 0;
    int bad = 0;
    int fd_count = 0;
    int fd_base;

    always @(negedge reloj) begin
        if (fin_dia === 1'b1)
            fd_count++;
    end

    function automatic snap_t mk(input logic [7:0] s, input logic [7:0] m,
                                 input logic [7:0] h, input logic p,
                                 input logic [1:0] c, input logic e, input logic f);
        snap_t r;
        r = {s, m, h, p, c, e, f};
        return r;
    endfunction

    task automatic cyc();
        @(posedge reloj);
        #1;
    endtask

    task automatic expect_snap(input string tag, input snap_t e);
        entry_t en;
        en.tag = tag;
        en.exp = e;
        sb.push_back(en);
    endtask

    task automatic check_out();
        entry_t e;
        snap_t  obs;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e   = sb.pop_front();
            obs = {seg_bcd, min_bcd, hora_bcd, pm, campo, editando, fin_dia};
            assert (obs === e.exp) begin
                $display("ok %s %h:%h:%h pm=%b campo=%0d ed=%b fd=%b", e.tag,
                         obs.hora, obs.min, obs.seg, obs.pm, obs.campo, obs.ed, obs.fd);
            end else begin
                bad++;
                $error("FAIL %s observed=%h:%h:%h pm=%b campo=%0d ed=%b fd=%b expected=%h:%h:%h pm=%b campo=%0d ed=%b fd=%b",
                       e.tag, obs.hora, obs.min, obs.seg, obs.pm, obs.campo, obs.ed, obs.fd,
                       e.exp.hora, e.exp.min, e.exp.seg, e.exp.pm, e.exp.campo, e.exp.ed, e.exp.fd);
            end
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) begin
            $display("ok %s value=%0d", tag, obs);
        end else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] btn);
        IN_bot_hora = btn;
        cyc();
        IN_bot_hora = 4'b0000;
        cyc();
    endtask

    task automatic pressc(input string tag, input logic [3:0] btn, input snap_t e);
        IN_bot_hora = btn;
        expect_snap(tag, e);
        cyc();
        check_out();
        IN_bot_hora = 4'b0000;
        cyc();
    endtask

    task automatic reset_dut();
        resetM = 1'b0;
        #1;
        cyc();
        resetM = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset state in both display formats.
        repeat (3) cyc();
        expect_snap("reset_24h", mk(8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b0, 1'b0));
        check_out();
        F_H = 1'b1;
        #1;
        expect_snap("reset_12h", mk(8'h00, 8'h00, 8'h12, 1'b0, 2'd2, 1'b0, 1'b0));
        check_out();
        F_H = 1'b0;
        resetM = 1'b1;
        cyc();

        // 3661 seconds in RUN = 01:01:01, no end-of-day.
        fd_base = fd_count;
        tick_1hz = 1'b1;
        repeat (3661) cyc();
        tick_1hz = 1'b0;
        expect_snap("run_3661", mk(8'h01, 8'h01, 8'h01, 1'b0, 2'd2, 1'b0, 1'b0));
        check_out();
        check_val("run_no_fin_dia", fd_count - fd_base, 0);

        // Enter edit, hour 00 -> 23, frozen time, field saturation, seg wrap.
        reset_dut();
        Control = 2'b01;
        expect_snap("enter_edit", mk(8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0));
        cyc();
        check_out();
        pressc("dn_hora", 4'b0100, mk(8'h00, 8'h00, 8'h23, 1'b1, 2'd2, 1'b1, 1'b0));
        tick_1hz = 1'b1;
        repeat (3) cyc();
        tick_1hz = 1'b0;
        expect_snap("tick_frozen", mk(8'h00, 8'h00, 8'h23, 1'b1, 2'd2, 1'b1, 1'b0));
        check_out();
        pressc("der_1", 4'b0001, mk(8'h00, 8'h00, 8'h23, 1'b1, 2'd1, 1'b1, 1'b0));
        pressc("der_2", 4'b0001, mk(8'h00, 8'h00, 8'h23, 1'b1, 2'd0, 1'b1, 1'b0));
        pressc("der_sat", 4'b0001, mk(8'h00, 8'h00, 8'h23, 1'b1, 2'd0, 1'b1, 1'b0));
        pressc("dn_seg_wrap", 4'b0100, mk(8'h59, 8'h00, 8'h23, 1'b1, 2'd0, 1'b1, 1'b0));
        pressc("up_seg_wrap", 4'b1000, mk(8'h00, 8'h00, 8'h23, 1'b1, 2'd0, 1'b1, 1'b0));

        // Level-held buttons give one edge only; up beats left.
        IN_bot_hora = 4'b1000;
        expect_snap("hold_first", mk(8'h01, 8'h00, 8'h23, 1'b1, 2'd0, 1'b1, 1'b0));
        cyc();
        check_out();
        repeat (9) cyc();
        expect_snap("hold_10", mk(8'h01, 8'h00, 8'h23, 1'b1, 2'd0, 1'b1, 1'b0));
        check_out();
        IN_bot_hora = 4'b1100;
        expect_snap("hold_add_dn", mk(8'h00, 8'h00, 8'h23, 1'b1, 2'd0, 1'b1, 1'b0));
        cyc();
        check_out();
        IN_bot_hora = 4'b0000;
        cyc();
        pressc("up_over_left", 4'b1010, mk(8'h01, 8'h00, 8'h23, 1'b1, 2'd0, 1'b1, 1'b0));

        // Preload 23:59:58, leave edit, roll over midnight.
        repeat (3) press(4'b0100);
        press(4'b0010);
        press(4'b0100);
        expect_snap("preload", mk(8'h58, 8'h59, 8'h23, 1'b1, 2'd1, 1'b1, 1'b0));
        check_out();
        Control = 2'b00;
        expect_snap("exit_edit", mk(8'h58, 8'h59, 8'h23, 1'b1, 2'd1, 1'b0, 1'b0));
        cyc();
        check_out();
        fd_base = fd_count;
        tick_1hz = 1'b1;
        expect_snap("tick_5959", mk(8'h59, 8'h59, 8'h23, 1'b1, 2'd1, 1'b0, 1'b0));
        cyc();
        check_out();
        expect_snap("rollover", mk(8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 1'b0, 1'b1));
        cyc();
        tick_1hz = 1'b0;
        check_out();
        expect_snap("fin_dia_drop", mk(8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0));
        cyc();
        check_out();
        F_H = 1'b1;
        #1;
        expect_snap("midnight_12h", mk(8'h00, 8'h00, 8'h12, 1'b0, 2'd1, 1'b0, 1'b0));
        check_out();
        check_val("fin_dia_pulses", fd_count - fd_base, 1);
        F_H = 1'b0;

        // Editing through 00 must not pulse fin_dia; then build 14:37:05.
        Control = 2'b01;
        cyc();
        press(4'b0100);
        pressc("edit_wrap_no_fd", 4'b1000, mk(8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0));
        repeat (14) press(4'b1000);
        press(4'b0001);
        repeat (37) press(4'b1000);
        press(4'b0001);
        repeat (5) press(4'b1000);
        F_H = 1'b1;
        #1;
        expect_snap("preload_143705", mk(8'h05, 8'h37, 8'h02, 1'b1, 2'd0, 1'b1, 1'b0));
        check_out();

        // Asynchronous reset mid-edit, then a button held across release.
        Control = 2'b00;
        IN_bot_hora = 4'b1000;
        resetM = 1'b0;
        #1;
        expect_snap("async_reset", mk(8'h00, 8'h00, 8'h12, 1'b0, 2'd2, 1'b0, 1'b0));
        check_out();
        cyc();
        resetM = 1'b1;
        cyc();
        cyc();
        expect_snap("held_after_reset", mk(8'h00, 8'h00, 8'h12, 1'b0, 2'd2, 1'b0, 1'b0));
        check_out();
        IN_bot_hora = 4'b0000;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reloj_hora_ajustable.md
Name: reloj_hora_ajustable

Overview:
Time-of-day keeper that consumes the hour-button vector and the mode/format bits produced by the port-decode stage (IN_bot_hora, Control, F_H).
- In run mode it counts seconds, minutes and hours from a 1 Hz enable.
- In edit mode it lets the user select a field and increment or decrement it with the four buttons.
- It drives BCD time to the display/VGA path and emits an end-of-day pulse to the date block.

Parameters:
EDIT_CODE, 2'b01, Control value that selects hour-edit mode
TICK_DIV, 1, number of tick_1hz pulses per second; kept at 1 on hardware, raised only for fast benches

Ports:
reloj  in  1  system clock
resetM  in  1  asynchronous, active-low reset
tick_1hz  in  1  one-cycle enable, one pulse per second
Control  in  2  mode word from the port-decode stage
F_H  in  1  display format: 0 = 24 h, 1 = 12 h
IN_bot_hora  in  4  level-held button vector; bit3 up, bit2 down, bit1 field-left, bit0 field-right
seg_bcd  out  8  seconds, two BCD digits
min_bcd  out  8  minutes, two BCD digits
hora_bcd  out  8  hours, two BCD digits, formatted per F_H
pm  out  1  1 when internal hour >= 12; valid in both formats
campo  out  2  field being edited: 0 = seg, 1 = min, 2 = hora
editando  out  1  1 while in EDIT state
fin_dia  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover in RUN

Behaviour:
- Reset (resetM = 0, asynchronous): internal time 00:00:00, state RUN, campo = 2, btn_prev = 0, tick divider = 0, fin_dia = 0.
- Output values at reset: hora_bcd = 8'h00 in 24 h mode or 8'h12 in 12 h mode; seg_bcd = min_bcd = 8'h00; pm = 0.
- Internal time is held as 24 h BCD (hour 00–23, min/sec 00–59).
- hora_bcd and pm are combinational from the internal hour and F_H:
  - 12 h mapping: 00 -> 12, 01–12 unchanged, 13–23 -> 01–11.
  - F_H never alters stored time.
- FSM states:
  - RUN -> EDIT when Control == EDIT_CODE; on entry, campo <= 2.
  - EDIT -> RUN when Control != EDIT_CODE.
  - Transitions are registered; on a transition cycle, inputs are processed by the pre-transition state.
- RUN:
  - Each counted tick advances seconds with carry into minutes and hours.
  - Button presses are ignored in RUN, but btn_prev still tracks the inputs.
- EDIT:
  - tick_1hz is ignored; time freezes, and the tick divider holds its value.
  - Press vector = IN_bot_hora & ~btn_prev, with btn_prev registered every cycle.
  - Exactly one action per cycle, priority up > down > left > right.
  - up/down: +1/−1 on the selected field with wrap (59<->00 for seg/min, 23<->00 for hora); no carry into neighbouring fields.
  - left: campo + 1, saturating at 2. right: campo − 1, saturating at 0.
- The input vector is level-held. Writing the same code twice with no intervening 0000 produces no second edge; firmware writes 00 between presses.
- fin_dia:
  - Registered one-cycle pulse in the cycle after the tick that wraps 23:59:59 -> 00:00:00.
  - Never asserted in EDIT, including when editing to or through 00:00:00.
- Latency: counted tick to updated outputs is 1 cycle; edge press to updated field is 1 cycle.
- Reset mid-edit: returns to RUN at 00:00:00. A button held across reset release produces an edge on the first cycle after release, but it has no effect because the state is RUN.
- All BCD digits stay legal (0–9) at every cycle; illegal codes are unreachable.

Decomposition:
- Shared package holds:
  - button bit indices (BTN_UP = 3, BTN_DN = 2, BTN_IZQ = 1, BTN_DER = 0)
  - campo codes (CAMPO_SEG = 0, CAMPO_MIN = 1, CAMPO_HORA = 2)
  - EDIT_CODE default
  - FSM state encoding
- One sub-module, contador_bcd_mod:
  - 2-digit BCD up/down counter with parameter MAX (59 or 23) and wrap.
  - Inputs: inc, dec.
  - Output: carry, asserted on MAX -> 0 via inc only.
  - Instantiated three times.

Test Plan:
- Reset then 3661 tick_1hz pulses in RUN -> seg 8'h01, min 8'h01, hora 8'h01, fin_dia never high.
- Preload 23:59:58 via edit, return to RUN, 2 ticks -> 00:00:00, fin_dia high exactly 1 cycle after the 2nd tick, hora_bcd = 8'h12 when F_H = 1.
- Control = 2'b01; IN_bot_hora 0100 / 0000 once -> editando = 1, campo = 2, hora 00 -> 23, no fin_dia; ticks during edit leave seg unchanged.
- In EDIT: right, right, right (each with 0000 between) -> campo 1, 0, 0 (saturates); up on seg at 59 -> 00, min unchanged.
- Hold IN_bot_hora = 1000 for 10 cycles, then 1100 -> exactly one increment total (1100 gives only a down-bit edge, so one decrement occurs); then 1010 from 0000 -> only the increment applies.
- Assert resetM low mid-edit at 14:37:05 with F_H = 1 -> immediate 00:00:00, editando = 0, hora_bcd = 8'h12, pm = 0.
